reg_file_sb: RTL and testbench



---
 rtl/reg_file_sb.sv | 109 ++++++++++
 tb/tb_reg_file_sb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Parametrised integer register file: two async read ports, one sync write port,
// x0 hardwired to zero, optional write bypass, post-reset clear sweep and RAW/WAW scoreboard.
module reg_file_sb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NREGS      = 32,
  parameter int unsigned AW         = $clog2(NREGS),
  parameter bit          BYPASS     = 1'b1,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            WE3,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  output logic            busy1,
  output logic            busy2,
  output logic            busy_rd
);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    idx, idx_nx;
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             sweep_wr;
  logic             wr_en;
  logic             fwd1, fwd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      idx   <= AW'(1);
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (state == CLEAR) begin
      if (INIT_CLEAR) begin
        idx_nx = idx + AW'(1);
        if (idx == AW'(NREGS - 1)) state_nx = RUN;
      end else begin
        state_nx = RUN;
      end
    end
  end

  always_comb begin
    ready = (state == RUN);
  end

  // Sweep and architectural writes are mutually exclusive: ready is low for the whole sweep.
  assign sweep_wr = INIT_CLEAR && (state == CLEAR);
  assign wr_en    = ready && WE3 && (A3 != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_wr)   regs[idx] <= '0;
      else if (wr_en) regs[A3]  <= WD3;
    end
  end

  // A new producer issuing in the same cycle as the old one's writeback keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (ready) begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (issue_en && issue_rd == AW'(i))  busy[i] <= 1'b1;
        else if (WE3 && A3 == AW'(i))        busy[i] <= 1'b0;
      end
    end
  end

  assign fwd1 = BYPASS && WE3 && (A3 == A1);
  assign fwd2 = BYPASS && WE3 && (A3 == A2);

  always_comb begin
    RD1     = '0;
    RD2     = '0;
    busy1   = 1'b0;
    busy2   = 1'b0;
    busy_rd = 1'b0;
    if (ready) begin
      if (A1 != '0) begin
        RD1   = fwd1 ? WD3 : regs[A1];
        busy1 = busy[A1] && !fwd1;
      end
      if (A2 != '0) begin
        RD2   = fwd2 ? WD3 : regs[A2];
        busy2 = busy[A2] && !fwd2;
      end
      if (issue_rd != '0) busy_rd = busy[issue_rd];
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: default, no-bypass/no-clear and 64x16 instances,
// table-driven vectors plus hand sequences, expectations queued and drained on sampling.
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default and BYPASS=0/INIT_CLEAR=0 instances share one set of inputs
  logic        rst = 1'b1;
  logic [4:0]  A1 = '0, A2 = '0, A3 = '0, issue_rd = '0;
  logic        WE3 = 1'b0, issue_en = 1'b0;
  logic [31:0] WD3 = '0;
  logic        ready0, ready1;
  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic        b1_0, b2_0, brd_0, b1_1, b2_1, brd_1;

  logic        rst2 = 1'b1, we2 = 1'b0, ien2 = 1'b0;
  logic [3:0]  a1_2 = '0, a2_2 = '0, a3_2 = '0, ird2 = '0;
  logic [63:0] wd2 = '0, rd1_2, rd2_2;
  logic        ready2, b1_2, b2_2, brd_2;

  reg_file_sb u_dut0 (
    .clk(clk), .rst(rst), .ready(ready0), .A1(A1), .A2(A2), .RD1(rd1_0), .RD2(rd2_0),
    .WE3(WE3), .A3(A3), .WD3(WD3), .issue_en(issue_en), .issue_rd(issue_rd),
    .busy1(b1_0), .busy2(b2_0), .busy_rd(brd_0));

  reg_file_sb #(.BYPASS(1'b0), .INIT_CLEAR(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .ready(ready1), .A1(A1), .A2(A2), .RD1(rd1_1), .RD2(rd2_1),
    .WE3(WE3), .A3(A3), .WD3(WD3), .issue_en(issue_en), .issue_rd(issue_rd),
    .busy1(b1_1), .busy2(b2_1), .busy_rd(brd_1));

  reg_file_sb #(.XLEN(64), .NREGS(16)) u_dut2 (
    .clk(clk), .rst(rst2), .ready(ready2), .A1(a1_2), .A2(a2_2), .RD1(rd1_2), .RD2(rd2_2),
    .WE3(we2), .A3(a3_2), .WD3(wd2), .issue_en(ien2), .issue_rd(ird2),
    .busy1(b1_2), .busy2(b2_2), .busy_rd(brd_2));

  localparam int S_RD1 = 0, S_RD2 = 1, S_B1 = 2, S_B2 = 3, S_BRD = 4, S_RDY = 5;
  localparam int S_RDY1 = 6, S_RD1_1 = 7, S_RD2_1 = 8, S_B1_1 = 9, S_B2_1 = 10, S_BRD_1 = 11;
  localparam int S_RDY2 = 12, S_RD1_2 = 13, S_RD2_2 = 14, S_B1_2 = 15, S_B2_2 = 16, S_BRD_2 = 17;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  typedef struct {
    int          sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic push(input int sel, input logic [63:0] val, input string name);
    exp_t e;
    e.sel = sel; e.val = val; e.name = name;
    sbq.push_back(e);
  endtask

  function automatic logic [63:0] actual(input int sel);
    case (sel)
      S_RD1:   return 64'(rd1_0);
      S_RD2:   return 64'(rd2_0);
      S_B1:    return 64'(b1_0);
      S_B2:    return 64'(b2_0);
      S_BRD:   return 64'(brd_0);
      S_RDY:   return 64'(ready0);
      S_RDY1:  return 64'(ready1);
      S_RD1_1: return 64'(rd1_1);
      S_RD2_1: return 64'(rd2_1);
      S_B1_1:  return 64'(b1_1);
      S_B2_1:  return 64'(b2_1);
      S_BRD_1: return 64'(brd_1);
      S_RDY2:  return 64'(ready2);
      S_RD1_2: return rd1_2;
      S_RD2_2: return rd2_2;
      S_B1_2:  return 64'(b1_2);
      S_B2_2:  return 64'(b2_2);
      default: return 64'(brd_2);
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [63:0] a;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = actual(e.sel);
      n_chk++;
      if (a !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %0h, expected %0h", e.name, a, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered with rst already low; P1 is the first edge with rst=0.
  task automatic sweep_check();
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk);
      @(negedge clk);
      push(S_RDY, 64'(k == 31), $sformatf("ready_sweep_k%0d", k));
      push(S_RD1, 64'h0, $sformatf("rd1_sweep_k%0d", k));
      if (k == 1) push(S_RDY1, 64'h1, "ready_noclear_k1");
      drain();
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  a1, a2;
    logic        ien;
    logic [4:0]  ird;
    logic [31:0] rd1, rd2;
    logic        b1, b2, brd;
    logic [31:0] nb_rd1;
  } vec_t;

  vec_t tv[16];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    //        we    a3     wd            a1     a2     ien   ird     rd1           rd2           b1    b2    brd   nb_rd1
    tv[0]  = '{1'b1, 5'd0, 32'h1234,     5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
    tv[1]  = '{1'b1, 5'd5, 32'hA5A5_0001,5'd5,  5'd6,  1'b0, 5'd0,  32'hA5A5_0001,32'h0,        1'b0, 1'b0, 1'b0, DB};
    tv[2]  = '{1'b0, 5'd0, 32'h0,        5'd5,  5'd0,  1'b0, 5'd0,  32'hA5A5_0001,32'h0,        1'b0, 1'b0, 1'b0, 32'hA5A5_0001};
    tv[3]  = '{1'b1, 5'd7, 32'h55,       5'd7,  5'd7,  1'b0, 5'd0,  32'h55,       32'h55,       1'b0, 1'b0, 1'b0, DB};
    tv[4]  = '{1'b0, 5'd0, 32'h0,        5'd7,  5'd7,  1'b0, 5'd0,  32'h55,       32'h55,       1'b0, 1'b0, 1'b0, 32'h55};
    tv[5]  = '{1'b0, 5'd0, 32'h0,        5'd9,  5'd9,  1'b1, 5'd9,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, DB};
    tv[6]  = '{1'b0, 5'd0, 32'h0,        5'd9,  5'd10, 1'b0, 5'd9,  32'h0,        32'h0,        1'b1, 1'b0, 1'b1, DB};
    tv[7]  = '{1'b1, 5'd9, 32'h99,       5'd9,  5'd9,  1'b0, 5'd9,  32'h99,       32'h99,       1'b0, 1'b0, 1'b1, DB};
    tv[8]  = '{1'b0, 5'd0, 32'h0,        5'd9,  5'd0,  1'b0, 5'd9,  32'h99,       32'h0,        1'b0, 1'b0, 1'b0, 32'h99};
    tv[9]  = '{1'b1, 5'd9, 32'h77,       5'd9,  5'd9,  1'b1, 5'd9,  32'h77,       32'h77,       1'b0, 1'b0, 1'b0, 32'h99};
    tv[10] = '{1'b0, 5'd0, 32'h0,        5'd9,  5'd9,  1'b0, 5'd9,  32'h77,       32'h77,       1'b1, 1'b1, 1'b1, 32'h77};
    tv[11] = '{1'b1, 5'd9, 32'h88,       5'd2,  5'd9,  1'b0, 5'd9,  32'h0,        32'h88,       1'b0, 1'b0, 1'b1, DB};
    tv[12] = '{1'b1, 5'd4, 32'h44,       5'd4,  5'd9,  1'b0, 5'd4,  32'h44,       32'h88,       1'b0, 1'b0, 1'b0, DB};
    tv[13] = '{1'b0, 5'd0, 32'h0,        5'd4,  5'd9,  1'b0, 5'd4,  32'h44,       32'h88,       1'b0, 1'b0, 1'b0, 32'h44};
    tv[14] = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd0,  1'b1, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0};
    tv[15] = '{1'b0, 5'd0, 32'h0,        5'd0,  5'd3,  1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0};

    // Reset state
    A1 = 5'd5;
    tick(); tick();
    @(negedge clk);
    push(S_RDY, 64'h0, "reset_ready0");
    push(S_RDY1, 64'h0, "reset_ready1");
    push(S_RD1, 64'h0, "reset_rd1");
    push(S_B1, 64'h0, "reset_busy1");
    drain();
    rst = 1'b0;
    sweep_check();

    // Fill with a pattern, then reset and confirm the sweep clears it
    for (int r = 1; r < 32; r++) begin
      WE3 = 1'b1; A3 = 5'(r); WD3 = DB;
      tick();
    end
    WE3 = 1'b0;
    A1 = 5'd17;
    @(negedge clk);
    push(S_RD1, 64'(DB), "prefill_rd1");
    drain();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sweep_check();
    for (int r = 0; r < 32; r++) begin
      A1 = 5'(r); A2 = 5'(31 - r);
      @(negedge clk);
      push(S_RD1, 64'h0, $sformatf("cleared_rd1_r%0d", r));
      push(S_RD2, 64'h0, $sformatf("cleared_rd2_r%0d", 31 - r));
      drain();
    end

    // Write, x0, bypass and scoreboard vectors
    for (int i = 0; i < 16; i++) begin
      tick();
      WE3 = tv[i].we; A3 = tv[i].a3; WD3 = tv[i].wd;
      A1 = tv[i].a1; A2 = tv[i].a2; issue_en = tv[i].ien; issue_rd = tv[i].ird;
      push(S_RD1, 64'(tv[i].rd1), $sformatf("v%0d_rd1", i));
      push(S_RD2, 64'(tv[i].rd2), $sformatf("v%0d_rd2", i));
      push(S_B1, 64'(tv[i].b1), $sformatf("v%0d_busy1", i));
      push(S_B2, 64'(tv[i].b2), $sformatf("v%0d_busy2", i));
      push(S_BRD, 64'(tv[i].brd), $sformatf("v%0d_busy_rd", i));
      push(S_RD1_1, 64'(tv[i].nb_rd1), $sformatf("v%0d_nobypass_rd1", i));
      @(negedge clk);
      drain();
    end

    // Writeback masking present only with bypass; busy_rd never masked
    tick();
    WE3 = 1'b0; issue_en = 1'b1; issue_rd = 5'd12; A1 = 5'd12; A2 = 5'd12;
    tick();
    issue_en = 1'b0; WE3 = 1'b1; A3 = 5'd12; WD3 = 32'hC0C0;
    push(S_RD1, 64'h0000_C0C0, "wb12_rd1");
    push(S_B1, 64'h0, "wb12_busy1");
    push(S_B2, 64'h0, "wb12_busy2");
    push(S_BRD, 64'h1, "wb12_busy_rd");
    push(S_RD2_1, 64'(DB), "wb12_nobypass_rd2");
    push(S_B1_1, 64'h1, "wb12_nobypass_busy1");
    push(S_B2_1, 64'h1, "wb12_nobypass_busy2");
    push(S_BRD_1, 64'h1, "wb12_nobypass_busy_rd");
    @(negedge clk);
    drain();
    tick();
    WE3 = 1'b0;

    // Reset in the middle of a sweep, with writes and issues attempted throughout
    A1 = 5'd5; A2 = 5'd0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      WE3 = k[0]; A3 = 5'd3; WD3 = 32'h333; issue_en = 1'b1; issue_rd = 5'd3;
      @(negedge clk);
      push(S_RDY, 64'h0, $sformatf("midsweep_ready_k%0d", k));
      push(S_RD1, 64'h0, $sformatf("midsweep_rd1_k%0d", k));
      push(S_BRD, 64'h0, $sformatf("midsweep_busy_rd_k%0d", k));
      drain();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    WE3 = 1'b1;
    sweep_check();
    WE3 = 1'b0; issue_en = 1'b0; A1 = 5'd3; A2 = 5'd9;
    #1;
    push(S_RD1, 64'h0, "post_abort_rd1_reg3");
    push(S_RD2, 64'h0, "post_abort_rd2_reg9");
    push(S_B1, 64'h0, "post_abort_busy1_reg3");
    drain();

    // 64-bit x 16 instance
    @(negedge clk);
    tick();
    rst2 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      push(S_RDY2, 64'(k == 15), $sformatf("w64_ready_k%0d", k));
      drain();
    end
    we2 = 1'b1; a3_2 = 4'd15; wd2 = 64'hFFFF_FFFF_0000_0001;
    ien2 = 1'b1; ird2 = 4'd15; a1_2 = 4'd15; a2_2 = 4'd0;
    #1;
    push(S_RD1_2, 64'hFFFF_FFFF_0000_0001, "w64_bypass_rd1");
    push(S_BRD_2, 64'h0, "w64_busy_rd_before");
    drain();
    tick();
    we2 = 1'b0; ien2 = 1'b0; a2_2 = 4'd15;
    #1;
    push(S_RD1_2, 64'hFFFF_FFFF_0000_0001, "w64_stored_rd1");
    push(S_BRD_2, 64'h1, "w64_busy_rd_set_wins");
    push(S_B1_2, 64'h1, "w64_busy1");
    push(S_B2_2, 64'h1, "w64_busy2");
    drain();
    we2 = 1'b1; wd2 = 64'h2; a2_2 = 4'd0;
    #1;
    push(S_RD1_2, 64'h2, "w64_wb_rd1");
    push(S_RD2_2, 64'h0, "w64_x0_rd2");
    push(S_B1_2, 64'h0, "w64_wb_busy1_masked");
    push(S_BRD_2, 64'h1, "w64_wb_busy_rd");
    drain();
    tick();
    we2 = 1'b0;
    #1;
    push(S_RD1_2, 64'h2, "w64_after_rd1");
    push(S_BRD_2, 64'h0, "w64_after_busy_rd");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
